// File: rtl/logic_trace_ctrl_mc_if.sv
// Command/trace bus of the trace controller: board qualifiers and command word in,
// per-channel strobes and status out.
interface logic_trace_ctrl_mc_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NB_CHAN = 4
);
  logic                carte_i;
  logic [3:0]          fpga_i;
  logic [3:0]          id_i;
  logic [DATA_W-1:0]   fp1_data_i;
  logic                fp1_dv_i;
  logic                ctrl_trce_i;
  logic                enable_o;
  logic                detect_data_o;
  logic [NB_CHAN-1:0]  w_addr_o;
  logic [NB_CHAN-1:0]  r_addr_o;
  logic [NB_CHAN-1:0]  init_o;
  logic [NB_CHAN-1:0]  read_enable_o;
  logic [NB_CHAN-1:0]  write_test_data_o;
  logic                busy_o;
  logic                cmd_err_o;
  logic                timeout_o;

  modport master (
    output carte_i, fpga_i, id_i, fp1_data_i, fp1_dv_i, ctrl_trce_i,
    input  enable_o, detect_data_o, w_addr_o, r_addr_o, init_o,
           read_enable_o, write_test_data_o, busy_o, cmd_err_o, timeout_o
  );

  modport slave (
    input  carte_i, fpga_i, id_i, fp1_data_i, fp1_dv_i, ctrl_trce_i,
    output enable_o, detect_data_o, w_addr_o, r_addr_o, init_o,
           read_enable_o, write_test_data_o, busy_o, cmd_err_o, timeout_o
  );
endinterface

// File: rtl/logic_trace_ctrl_mc.sv
// Trace controller: decodes command words inside the trace-control window and drives
// per-channel address/init strobes or stream enables, with a stream timeout.
module logic_trace_ctrl_mc #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NB_CHAN    = 4,
  parameter int unsigned PULSE_MODE = 1,
  parameter int unsigned TMO_CYC    = 1024
) (
  input  logic                  clk_ref,
  input  logic                  rst,
  logic_trace_ctrl_mc_if.slave  bus
);
  localparam int unsigned CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROG, S_STREAM} state_t;
  typedef enum logic [2:0] {K_NONE, K_WA, K_IN, K_RA, K_RD, K_WR} kind_t;

  state_t               r_state, w_nxt_state;
  logic [CNT_W-1:0]     r_cnt, w_nxt_cnt;
  logic                 r_rearm, w_nxt_rearm;
  logic [NB_CHAN-1:0]   r_w_addr, r_r_addr, r_init, r_rd_en, r_wr_en;
  logic [NB_CHAN-1:0]   w_nxt_w_addr, w_nxt_r_addr, w_nxt_init, w_nxt_rd_en, w_nxt_wr_en;
  logic                 r_busy, r_err, r_tmo, w_nxt_err, w_nxt_tmo;

  logic                 w_enable, w_detect, w_cap;
  logic                 w_op_wa, w_op_ra, w_op_rd, w_op_wr, w_op_in, w_bcast;
  logic [3:0]           w_ch;
  logic [2:0]           w_nops;
  logic                 w_bad_bc, w_bad_ch;
  logic [NB_CHAN-1:0]   w_mask;
  kind_t                w_kind;
  logic                 w_clr;
  logic                 w_unused_data;

  assign w_enable = (bus.id_i == bus.fpga_i) && bus.carte_i;
  assign w_detect = bus.fp1_dv_i && bus.ctrl_trce_i;
  assign w_cap    = w_detect && w_enable && (r_state == S_IDLE) && !r_rearm;

  assign w_op_wa  = bus.fp1_data_i[0];
  assign w_op_ra  = bus.fp1_data_i[1];
  assign w_op_rd  = bus.fp1_data_i[2];
  assign w_op_wr  = bus.fp1_data_i[3];
  assign w_op_in  = bus.fp1_data_i[15];
  assign w_bcast  = bus.fp1_data_i[14];
  assign w_ch     = bus.fp1_data_i[11:8];
  assign w_unused_data = ^bus.fp1_data_i;

  assign w_nops   = 3'(w_op_wa) + 3'(w_op_ra) + 3'(w_op_rd) + 3'(w_op_wr) + 3'(w_op_in);
  assign w_bad_bc = w_bcast && (w_kind != K_IN);
  assign w_bad_ch = !w_bcast && ({1'b0, w_ch} >= 5'(NB_CHAN));
  assign w_mask   = w_bcast ? {NB_CHAN{1'b1}} : (NB_CHAN'(1) << w_ch);

  // Opcode priority WA > IN > RA > RD > WR
  always_comb begin
    w_kind = K_NONE;
    if (w_op_wa)      w_kind = K_WA;
    else if (w_op_in) w_kind = K_IN;
    else if (w_op_ra) w_kind = K_RA;
    else if (w_op_rd) w_kind = K_RD;
    else if (w_op_wr) w_kind = K_WR;
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_rearm  = r_rearm && bus.ctrl_trce_i;
    w_nxt_w_addr = r_w_addr;
    w_nxt_r_addr = r_r_addr;
    w_nxt_init   = r_init;
    w_nxt_rd_en  = r_rd_en;
    w_nxt_wr_en  = r_wr_en;
    w_nxt_err    = 1'b0;
    w_nxt_tmo    = 1'b0;
    w_clr        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cap && (w_kind != K_NONE)) begin
          w_nxt_err = (w_nops > 3'd1) || w_bad_bc || w_bad_ch;
          if (!w_bad_bc && !w_bad_ch) begin
            w_nxt_cnt = '0;
            case (w_kind)
              K_WA:    begin w_nxt_w_addr = w_mask; w_nxt_state = S_PROG;   end
              K_IN:    begin w_nxt_init   = w_mask; w_nxt_state = S_PROG;   end
              K_RA:    begin w_nxt_r_addr = w_mask; w_nxt_state = S_PROG;   end
              K_RD:    begin w_nxt_rd_en  = w_mask; w_nxt_state = S_STREAM; end
              K_WR:    begin w_nxt_wr_en  = w_mask; w_nxt_state = S_STREAM; end
              default: w_nxt_state = S_IDLE;
            endcase
          end
        end
      end
      S_PROG: begin
        if (PULSE_MODE != 0) w_clr = 1'b1;
        if (!bus.ctrl_trce_i) begin
          w_clr       = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      S_STREAM: begin
        if (!bus.ctrl_trce_i) begin
          w_clr       = 1'b1;
          w_nxt_state = S_IDLE;
        end else if ((TMO_CYC != 0) && (r_cnt == TMO_LAST)) begin
          // Abort the stream; a new capture needs a fresh rising window
          w_clr       = 1'b1;
          w_nxt_tmo   = 1'b1;
          w_nxt_rearm = 1'b1;
          w_nxt_state = S_IDLE;
        end else if (r_cnt != '1) begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_nxt_state = S_IDLE;
      end
    endcase

    if (w_clr) begin
      w_nxt_w_addr = '0;
      w_nxt_r_addr = '0;
      w_nxt_init   = '0;
      w_nxt_rd_en  = '0;
      w_nxt_wr_en  = '0;
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rearm  <= 1'b0;
      r_w_addr <= '0;
      r_r_addr <= '0;
      r_init   <= '0;
      r_rd_en  <= '0;
      r_wr_en  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_rearm  <= w_nxt_rearm;
      r_w_addr <= w_nxt_w_addr;
      r_r_addr <= w_nxt_r_addr;
      r_init   <= w_nxt_init;
      r_rd_en  <= w_nxt_rd_en;
      r_wr_en  <= w_nxt_wr_en;
      r_busy   <= (w_nxt_state != S_IDLE);
      r_err    <= w_nxt_err;
      r_tmo    <= w_nxt_tmo;
    end
  end

  assign bus.enable_o          = w_enable;
  assign bus.detect_data_o     = w_detect;
  assign bus.w_addr_o          = r_w_addr;
  assign bus.r_addr_o          = r_r_addr;
  assign bus.init_o            = r_init;
  assign bus.read_enable_o     = r_rd_en;
  assign bus.write_test_data_o = r_wr_en;
  assign bus.busy_o            = r_busy;
  assign bus.cmd_err_o         = r_err;
  assign bus.timeout_o         = r_tmo;
endmodule

// File: tb/tb_logic_trace_ctrl_mc.sv
// Scoreboard bench: two controllers (pulse and level strobe styles) share one stimulus
// stream; a transaction-level model predicts each response burst.
module tb_logic_trace_ctrl_mc;
  localparam int TMO = 1024;

  typedef struct {
    logic [19:0] strobes;   // {w_addr, r_addr, init, read_en, write_en}
    logic        err;
    int          len;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        carte, dv, ctrl;
  logic [3:0]  fpga, id;
  logic [15:0] data;

  int total = 0;
  int bad   = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  logic_trace_ctrl_mc_if #(.DATA_W(16), .NB_CHAN(4)) if_p1 ();
  logic_trace_ctrl_mc_if #(.DATA_W(16), .NB_CHAN(4)) if_p0 ();

  assign if_p1.carte_i = carte;  assign if_p0.carte_i = carte;
  assign if_p1.fpga_i  = fpga;   assign if_p0.fpga_i  = fpga;
  assign if_p1.id_i    = id;     assign if_p0.id_i    = id;
  assign if_p1.fp1_data_i  = data;  assign if_p0.fp1_data_i  = data;
  assign if_p1.fp1_dv_i    = dv;    assign if_p0.fp1_dv_i    = dv;
  assign if_p1.ctrl_trce_i = ctrl;  assign if_p0.ctrl_trce_i = ctrl;

  logic_trace_ctrl_mc #(.DATA_W(16), .NB_CHAN(4), .PULSE_MODE(1), .TMO_CYC(TMO)) u_p1 (
    .clk_ref(clk), .rst(rst), .bus(if_p1));
  logic_trace_ctrl_mc #(.DATA_W(16), .NB_CHAN(4), .PULSE_MODE(0), .TMO_CYC(TMO)) u_p0 (
    .clk_ref(clk), .rst(rst), .bus(if_p0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [19:0] strobes(input int d);
    if (d == 1)
      return {if_p1.w_addr_o, if_p1.r_addr_o, if_p1.init_o, if_p1.read_enable_o, if_p1.write_test_data_o};
    return {if_p0.w_addr_o, if_p0.r_addr_o, if_p0.init_o, if_p0.read_enable_o, if_p0.write_test_data_o};
  endfunction

  function automatic logic err_of(input int d);
    return (d == 1) ? if_p1.cmd_err_o : if_p0.cmd_err_o;
  endfunction

  function automatic logic tmo_of(input int d);
    return (d == 1) ? if_p1.timeout_o : if_p0.timeout_o;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 1) ? if_p1.busy_o : if_p0.busy_o;
  endfunction

  // Response predicted from the command-word rules; returns 0 when nothing should happen
  function automatic bit model(input logic [15:0] d, input bit pulse, input int hold, output exp_t ex);
    int nops, slot;
    logic [3:0] mask;
    logic [3:0] one;
    ex.strobes = '0; ex.err = 1'b0; ex.len = 0; ex.tmo = 1'b0;
    nops = int'(d[0]) + int'(d[15]) + int'(d[1]) + int'(d[2]) + int'(d[3]);
    if (nops == 0) return 1'b0;
    if (d[0]) slot = 0; else if (d[15]) slot = 1; else if (d[1]) slot = 2;
    else if (d[2]) slot = 3; else slot = 4;
    ex.err = (nops > 1);
    if (d[14] && slot != 1) begin ex.err = 1'b1; return 1'b1; end
    if (!d[14] && d[11:8] >= 4) begin ex.err = 1'b1; return 1'b1; end
    one  = 4'd1;
    mask = d[14] ? 4'hF : (one << d[11:8]);
    case (slot)
      0: ex.strobes[19:16] = mask;
      1: ex.strobes[11:8]  = mask;
      2: ex.strobes[15:12] = mask;
      3: ex.strobes[7:4]   = mask;
      default: ex.strobes[3:0] = mask;
    endcase
    if (slot >= 3) begin
      ex.tmo = (hold + 1 > TMO);
      ex.len = ex.tmo ? TMO : hold + 1;
    end else begin
      ex.len = pulse ? 1 : hold + 1;
    end
    return 1'b1;
  endfunction

  task automatic mon(input int d);
    logic [19:0] s, s0;
    logic e0, to;
    int len;
    exp_t ex;
    forever begin
      @(negedge clk);
      s = strobes(d);
      if (s != '0 || err_of(d) || tmo_of(d)) begin
        s0 = s; e0 = err_of(d); len = 0;
        while (s == s0 && s0 != '0 && len < 4000) begin
          len++;
          @(negedge clk);
          s = strobes(d);
        end
        to = tmo_of(d);
        if ((d == 1 ? q1.size() : q0.size()) == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event dut=%0d strobes=%h err=%0b required=none", d, s0, e0);
        end else begin
          ex = (d == 1) ? q1.pop_front() : q0.pop_front();
          chk($sformatf("strobes_d%0d", d), 32'(s0), 32'(ex.strobes));
          chk($sformatf("cmd_err_d%0d", d), 32'(e0), 32'(ex.err));
          chk($sformatf("length_d%0d", d), 32'(len), 32'(ex.len));
          chk($sformatf("timeout_d%0d", d), 32'(to), 32'(ex.tmo));
        end
      end
    end
  endtask

  initial mon(1);
  initial mon(0);

  task automatic send(input logic [15:0] d, input bit match, input int hold, input bit dv_hold);
    exp_t e1, e0;
    bit ev1, ev0, busy_mid;
    ev1 = 1'b0; ev0 = 1'b0;
    if (match) begin
      ev1 = model(d, 1'b1, hold, e1);
      ev0 = model(d, 1'b0, hold, e0);
    end
    if (ev1) q1.push_back(e1);
    if (ev0) q0.push_back(e0);
    busy_mid = ev1 && (e1.strobes != '0) && !e1.tmo;
    fpga = 4'd3; id = match ? 4'd3 : 4'd9; carte = 1'b1;
    data = d; dv = 1'b1; ctrl = 1'b1;
    #1;
    chk("enable_o", 32'(if_p1.enable_o), 32'(match));
    chk("detect_data_o", 32'(if_p0.detect_data_o), 32'd1);
    @(posedge clk); #1;
    if (!dv_hold) dv = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    chk("busy_window_d1", 32'(busy_of(1)), 32'(busy_mid));
    chk("busy_window_d0", 32'(busy_of(0)), 32'(busy_mid));
    ctrl = 1'b0; dv = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_after_d1", 32'(busy_of(1)), 32'd0);
    chk("busy_after_d0", 32'(busy_of(0)), 32'd0);
  endtask

  initial begin
    exp_t er;
    logic [15:0] d;
    rst = 1'b1; carte = 1'b0; dv = 1'b0; ctrl = 1'b0;
    fpga = '0; id = '0; data = '0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_strobes_d%0d", k), 32'(strobes(k)), 32'd0);
      chk($sformatf("reset_busy_d%0d", k), 32'(busy_of(k)), 32'd0);
      chk($sformatf("reset_err_d%0d", k), 32'({err_of(k), tmo_of(k)}), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h0201, 1'b1, 3, 1'b0);
    send(16'hC000, 1'b1, 2, 1'b0);
    send(16'h4004, 1'b1, 2, 1'b0);
    send(16'h0504, 1'b1, 2, 1'b0);
    send(16'h0007, 1'b1, 2, 1'b0);
    send(16'h0007, 1'b0, 2, 1'b0);
    send(16'h0002, 1'b1, 5, 1'b0);
    send(16'h0000, 1'b1, 1, 1'b0);
    send(16'h0108, 1'b1, 2000, 1'b1);
    send(16'h0304, 1'b1, 1023, 1'b0);
    send(16'h8300, 1'b1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      d = 16'(($urandom & 32'h30F0));
      d[0]  = ($urandom_range(0, 3) == 0);
      d[1]  = ($urandom_range(0, 3) == 0);
      d[2]  = ($urandom_range(0, 3) == 0);
      d[3]  = ($urandom_range(0, 3) == 0);
      d[15] = ($urandom_range(0, 3) == 0);
      d[14] = ($urandom_range(0, 4) == 0);
      d[11:8] = 4'($urandom_range(0, 5));
      send(d, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 6)), 1'b0);
    end

    // Reset in the middle of a stream aborts it silently
    er.strobes = 20'h00020; er.err = 1'b0; er.len = 10; er.tmo = 1'b0;
    q1.push_back(er); q0.push_back(er);
    fpga = 4'd3; id = 4'd3; carte = 1'b1; data = 16'h0104; dv = 1'b1; ctrl = 1'b1;
    @(posedge clk); #1 dv = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_strobes_d%0d", k), 32'(strobes(k)), 32'd0);
      chk($sformatf("abort_busy_d%0d", k), 32'(busy_of(k)), 32'd0);
      chk($sformatf("abort_err_tmo_d%0d", k), 32'({err_of(k), tmo_of(k)}), 32'd0);
    end
    ctrl = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pending_d1", 32'(q1.size()), 32'd0);
    chk("pending_d0", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
